// File: rtl/jdrosent_edge_event_arbiter_pkg.sv
// Shared types and constants for the edge-event arbiter: FSM encoding, widths
// and the round-robin pick helper.
package jdrosent_edge_event_arbiter_pkg;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned ID_W   = $clog2(N_REQ);
  localparam int unsigned HOLD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // First set bit of pend searching upward from ptr+1, wrapping around.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] pend,
                                               input logic [ID_W-1:0]  ptr);
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] pick;
    logic            found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned d = 1; d <= N_REQ; d++) begin
      idx = ID_W'((32'(ptr) + d) % N_REQ);
      if (!found && pend[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/jdrosent_sync_edge.sv
// One request line: multi-flop synchronizer, history flop and rising-edge
// detect (rise_c is combinational from flops only).
module jdrosent_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  output logic rise_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], req_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/jdrosent_edge_event_arbiter.sv
// Captures rising edges on N_REQ async request lines as pending events and
// serves them round-robin with fixed-length grant pulses separated by one gap.
module jdrosent_edge_event_arbiter
  import jdrosent_edge_event_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  id_o,
  output logic             busy_o,
  output logic             overflow_o
);

  logic [N_REQ-1:0]  rise_c;
  logic [N_REQ-1:0]  clr_c;
  logic [ID_W-1:0]   winner_c;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  pend_q, pend_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;

  for (genvar i = 0; i < N_REQ; i++) begin : g_sync
    jdrosent_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i (req_i[i]),
      .rise_c(rise_c[i])
    );
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    id_d     = id_q;
    clr_c    = '0;
    winner_c = rr_pick(pend_q, ptr_q);

    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (|pend_q) begin
          state_d = ST_GRANT;
          cnt_d   = HOLD_W'(HOLD_CYCLES - 1);
          ptr_d   = winner_c;
          grant_d = N_REQ'(1) << winner_c;
          id_d    = winner_c;
          clr_c   = N_REQ'(1) << winner_c;
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
          id_d    = '0;
        end
      end
      ST_GRANT: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          grant_d = '0;
          id_d    = '0;
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        id_d    = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    // A rise on the channel being served is a new event, so set beats clear.
    pend_d = (pend_q & ~clr_c) | rise_c;
    ovf_d  = ovf_q | (|(rise_c & pend_q & ~clr_c));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      cnt_q   <= '0;
      ptr_q   <= ID_W'(N_REQ - 1);
      grant_q <= '0;
      id_q    <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign grant_o    = grant_q;
  assign id_o       = id_q;
  assign busy_o     = busy_q;
  assign overflow_o = ovf_q;

endmodule
